// File: rtl/video_udp_line_unpack.sv
// Unpacks one-line-per-packet UDP video: validates the line header, converts RGB888 to RGB565 with x/y.
// Latency: every output is registered, one cycle after the eth_rec_en / rec_pkt_done input cycle.
// Backpressure: none upstream; a pixel arriving while fifo_full is high is dropped and ovf sticks until rst.
module video_udp_line_unpack #(
    parameter int         H_PIXELS  = 640,
    parameter int         V_LINES   = 480,
    parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eth_rec_en,
    input  logic [23:0] rx_data_24,
    input  logic        rec_pkt_done,
    input  logic [15:0] rec_byte_num,
    input  logic        fifo_full,
    output logic        pix_wr_en,
    output logic [15:0] pix_wr_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        line_done,
    output logic        frame_done,
    output logic        err_len,
    output logic        err_seq,
    output logic        ovf
);

    localparam logic [10:0] X_END      = 11'(H_PIXELS);
    localparam logic [10:0] Y_LAST     = 11'(V_LINES - 1);
    localparam logic [15:0] V_LIM      = 16'(V_LINES);
    localparam logic [15:0] GOOD_BYTES = 16'(3 + 3 * H_PIXELS);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PIX  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] x;
    logic [10:0] cur_y;
    logic [15:0] exp_y;

    state_t      st_nxt;
    logic [10:0] x_nxt;
    logic [10:0] cury_nxt;
    logic [15:0] expy_nxt;
    logic        wr_nxt;
    logic [15:0] wdat_nxt;
    logic [10:0] px_nxt;
    logic [10:0] py_nxt;
    logic        fs_nxt;
    logic        ld_nxt;
    logic        fd_nxt;
    logic        el_nxt;
    logic        es_nxt;
    logic        ovf_nxt;

    // Next-state: the incoming word is applied first, then packet end is judged on the post-word state.
    always_comb begin
        st_nxt   = state;
        x_nxt    = x;
        cury_nxt = cur_y;
        expy_nxt = exp_y;
        wr_nxt   = 1'b0;
        wdat_nxt = pix_wr_data;
        px_nxt   = pix_x;
        py_nxt   = pix_y;
        fs_nxt   = 1'b0;
        ld_nxt   = 1'b0;
        fd_nxt   = 1'b0;
        el_nxt   = 1'b0;
        es_nxt   = 1'b0;
        ovf_nxt  = ovf;

        if (eth_rec_en) begin
            case (state)
                S_HDR: begin
                    if (rx_data_24[23:16] != HDR_MAGIC) begin
                        st_nxt = S_DROP;
                    end else if (rx_data_24[15:0] >= V_LIM) begin
                        es_nxt = 1'b1;
                        st_nxt = S_DROP;
                    end else begin
                        // Line 0 always restarts a frame; other out-of-order lines are flagged but kept.
                        if (rx_data_24[15:0] == 16'd0)
                            fs_nxt = 1'b1;
                        else if (rx_data_24[15:0] != exp_y)
                            es_nxt = 1'b1;
                        cury_nxt = rx_data_24[10:0];
                        x_nxt    = 11'd0;
                        st_nxt   = S_PIX;
                    end
                end
                S_PIX: begin
                    if (x < X_END) begin
                        wdat_nxt = {rx_data_24[23:19], rx_data_24[15:10], rx_data_24[7:3]};
                        px_nxt   = x;
                        py_nxt   = cur_y;
                        wr_nxt   = !fifo_full;
                        if (fifo_full)
                            ovf_nxt = 1'b1;
                        x_nxt = x + 11'd1;
                    end else begin
                        el_nxt = 1'b1;
                        st_nxt = S_DROP;
                    end
                end
                default: ;
            endcase
        end

        if (rec_pkt_done) begin
            case (st_nxt)
                S_HDR: el_nxt = 1'b1;
                S_PIX: begin
                    if (x_nxt == X_END && rec_byte_num == GOOD_BYTES) begin
                        ld_nxt = 1'b1;
                        if (cury_nxt == Y_LAST) begin
                            fd_nxt   = 1'b1;
                            expy_nxt = 16'd0;
                        end else begin
                            expy_nxt = 16'(cury_nxt) + 16'd1;
                        end
                    end else begin
                        el_nxt = 1'b1;
                    end
                    st_nxt = S_HDR;
                end
                default: st_nxt = S_HDR;
            endcase
        end
    end

    // State, counters and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_HDR;
            x           <= 11'd0;
            cur_y       <= 11'd0;
            exp_y       <= 16'd0;
            pix_wr_en   <= 1'b0;
            pix_wr_data <= 16'd0;
            pix_x       <= 11'd0;
            pix_y       <= 11'd0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_seq     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state       <= st_nxt;
            x           <= x_nxt;
            cur_y       <= cury_nxt;
            exp_y       <= expy_nxt;
            pix_wr_en   <= wr_nxt;
            pix_wr_data <= wdat_nxt;
            pix_x       <= px_nxt;
            pix_y       <= py_nxt;
            frame_start <= fs_nxt;
            line_done   <= ld_nxt;
            frame_done  <= fd_nxt;
            err_len     <= el_nxt;
            err_seq     <= es_nxt;
            ovf         <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_video_udp_line_unpack.sv
// Randomized packet-level bench for video_udp_line_unpack against a per-packet behavioural model.
// Latency: outputs are collected by a negedge monitor and compared a few idle cycles after each packet.
// Backpressure: fifo_full windows are driven per packet; the model predicts dropped pixels and ovf.
module tb_video_udp_line_unpack;

    localparam int          H  = 16;
    localparam int          V  = 8;
    localparam logic [15:0] BN = 16'(3 + 3 * H);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eth_rec_en = 1'b0;
    logic [23:0] rx_data_24 = '0;
    logic        rec_pkt_done = 1'b0;
    logic [15:0] rec_byte_num = '0;
    logic        fifo_full = 1'b0;
    logic        pix_wr_en;
    logic [15:0] pix_wr_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_start, line_done, frame_done, err_len, err_seq, ovf;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state (written only by the monitor process)
    logic [37:0] act_q[$];
    int c_fs = 0, c_ld = 0, c_fd = 0, c_el = 0, c_es = 0, c_co = 0, c_fdld = 0;

    // Model state
    logic [15:0] m_exp_y = 16'd0;
    logic        m_ovf   = 1'b0;
    logic [23:0] pix [0:H+1];

    always #5 clk = ~clk;

    video_udp_line_unpack #(.H_PIXELS(H), .V_LINES(V), .HDR_MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .eth_rec_en(eth_rec_en), .rx_data_24(rx_data_24),
        .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num), .fifo_full(fifo_full),
        .pix_wr_en(pix_wr_en), .pix_wr_data(pix_wr_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_done(line_done), .frame_done(frame_done),
        .err_len(err_len), .err_seq(err_seq), .ovf(ovf)
    );

    always @(negedge clk) begin
        if (pix_wr_en) act_q.push_back({pix_wr_data, pix_x, pix_y});
        c_fs   = c_fs + int'(frame_start);
        c_ld   = c_ld + int'(line_done);
        c_fd   = c_fd + int'(frame_done);
        c_el   = c_el + int'(err_len);
        c_es   = c_es + int'(err_seq);
        c_co   = c_co + int'(pix_wr_en & line_done);
        c_fdld = c_fdld + int'(frame_done & line_done);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] d);
        int r, g, b;
        r = (int'(d) / 65536) % 256;
        g = (int'(d) / 256) % 256;
        b = int'(d) % 256;
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    function automatic logic [44:0] all_outs();
        return {pix_wr_en, pix_wr_data, pix_x, pix_y, frame_start, line_done,
                frame_done, err_len, err_seq, ovf};
    endfunction

    // npix < 0: empty packet (done only); npix == 0: header only.
    task automatic run_pkt(input string tag, input logic [7:0] mg, input logic [15:0] ln,
                           input int npix, input logic [15:0] bn, input int ff, input int fc,
                           input bit coinc, input logic [23:0] pat);
        logic [37:0] exp_q[$];
        int a0, s_fs, s_ld, s_fd, s_el, s_es, s_co, s_fdld;
        int e_fs, e_ld, e_fd, e_el, e_es, e_co;
        bit use_co, last_full;
        use_co = coinc && (npix > 0);
        for (int i = 0; i < H + 2; i++) pix[i] = (pat != 24'd0) ? pat : 24'($urandom);
        // Behavioural expectation for the whole packet
        e_fs = 0; e_ld = 0; e_fd = 0; e_el = 0; e_es = 0; e_co = 0;
        last_full = (npix - 1 >= ff) && (npix - 1 < ff + fc);
        if (npix < 0) begin
            e_el = 1;
        end else if (mg != 8'hA5) begin
            e_el = 0;
        end else if (int'(ln) >= V) begin
            e_es = 1;
        end else begin
            e_fs = (ln == 16'd0) ? 1 : 0;
            e_es = (ln != 16'd0 && ln != m_exp_y) ? 1 : 0;
            for (int i = 0; i < npix && i < H; i++) begin
                if (i >= ff && i < ff + fc) m_ovf = 1'b1;
                else exp_q.push_back({to565(pix[i]), 11'(i), 11'(ln)});
            end
            if (npix > H) begin
                e_el = 1;
            end else if (npix == H && bn == BN) begin
                e_ld = 1;
                e_co = (use_co && !last_full) ? 1 : 0;
                if (int'(ln) == V - 1) begin e_fd = 1; m_exp_y = 16'd0; end
                else m_exp_y = ln + 16'd1;
            end else begin
                e_el = 1;
            end
        end
        a0 = act_q.size(); s_fs = c_fs; s_ld = c_ld; s_fd = c_fd; s_el = c_el; s_es = c_es;
        s_co = c_co; s_fdld = c_fdld;
        // Drive the packet
        @(posedge clk); #1;
        if (npix >= 0) begin
            eth_rec_en = 1'b1; rx_data_24 = {mg, ln};
            @(posedge clk); #1;
            eth_rec_en = 1'b0;
        end
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            eth_rec_en = 1'b1; rx_data_24 = pix[i];
            fifo_full = (i >= ff && i < ff + fc);
            if (use_co && i == npix - 1) begin rec_pkt_done = 1'b1; rec_byte_num = bn; end
            @(posedge clk); #1;
            eth_rec_en = 1'b0; fifo_full = 1'b0; rec_pkt_done = 1'b0;
        end
        if (!use_co) begin
            rec_pkt_done = 1'b1; rec_byte_num = bn;
            @(posedge clk); #1;
            rec_pkt_done = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Compare
        check({tag, ".nwr"}, 64'(act_q.size() - a0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (a0 + i < act_q.size()) check({tag, ".wr"}, 64'(act_q[a0 + i]), 64'(exp_q[i]));
        check({tag, ".frame_start"}, 64'(c_fs - s_fs), 64'(e_fs));
        check({tag, ".line_done"}, 64'(c_ld - s_ld), 64'(e_ld));
        check({tag, ".frame_done"}, 64'(c_fd - s_fd), 64'(e_fd));
        check({tag, ".fd_with_ld"}, 64'(c_fdld - s_fdld), 64'(e_fd));
        check({tag, ".err_len"}, 64'(c_el - s_el), 64'(e_el));
        check({tag, ".err_seq"}, 64'(c_es - s_es), 64'(e_es));
        if (use_co) check({tag, ".wr_with_ld"}, 64'(c_co - s_co), 64'(e_co));
        check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    endtask

    initial begin
        int r, np;
        logic [15:0] ln, bn;
        logic [7:0] mg;
        #12;
        check("reset_outs", 64'(all_outs()), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_outs", 64'(all_outs()), 64'd0);

        // Good line and a full in-order frame
        run_pkt("good_line", 8'hA5, 16'd0, H, BN, 0, 0, 1'b0, 24'hFF8040);
        for (int l = 1; l < V; l++) run_pkt("frame", 8'hA5, 16'(l), H, BN, 0, 0, 1'b0, 24'd0);

        // Sequence errors
        for (int l = 0; l < 3; l++) run_pkt("seq_pre", 8'hA5, 16'(l), H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("seq_skip", 8'hA5, 16'd5, H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("seq_range", 8'hA5, 16'(V), H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("seq_after", 8'hA5, 16'd6, H, BN, 0, 0, 1'b0, 24'd0);

        // Length errors; a short line must leave the expected line number alone
        run_pkt("short", 8'hA5, 16'd7, H - 1, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("short_retry", 8'hA5, 16'd7, H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("long", 8'hA5, 16'd0, H + 1, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("bytes", 8'hA5, 16'd0, H, BN + 16'd1, 0, 0, 1'b0, 24'd0);
        run_pkt("empty", 8'hA5, 16'd0, -1, 16'd0, 0, 0, 1'b0, 24'd0);
        run_pkt("hdr_only", 8'hA5, 16'd0, 0, 16'd3, 0, 0, 1'b0, 24'd0);

        // Bad magic, then normal
        run_pkt("bad_magic", 8'h5A, 16'd3, H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("after_magic", 8'hA5, 16'd0, H, BN, 0, 0, 1'b0, 24'd0);

        // Backpressure and coincident last word
        run_pkt("fifo_full", 8'hA5, 16'd1, H, BN, 3, 10, 1'b0, 24'd0);
        run_pkt("ovf_sticky", 8'hA5, 16'd2, H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("coincident", 8'hA5, 16'd3, H, BN, 0, 0, 1'b1, 24'd0);

        // Reset in the middle of a packet
        @(posedge clk); #1;
        eth_rec_en = 1'b1; rx_data_24 = {8'hA5, 16'd4};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx_data_24 = 24'($urandom);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outs", 64'(all_outs()), 64'd0);
        eth_rec_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_exp_y = 16'd0; m_ovf = 1'b0;
        run_pkt("after_reset", 8'hA5, 16'd0, H, BN, 0, 0, 1'b0, 24'd0);
        run_pkt("after_reset2", 8'hA5, 16'd1, H, BN, 0, 0, 1'b1, 24'd0);

        // Randomized packets
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) ln = m_exp_y;
            else if (r < 9) ln = 16'($urandom_range(0, V - 1));
            else ln = 16'(V + int'($urandom_range(0, 3)));
            mg = ($urandom_range(0, 9) == 0) ? 8'h5A : 8'hA5;
            r = int'($urandom_range(0, 7));
            np = (r == 0) ? H - 1 : (r == 1) ? H + 1 : H;
            bn = ($urandom_range(0, 7) == 0) ? BN + 16'd1 : BN;
            run_pkt("rand", mg, ln, np, bn, int'($urandom_range(0, H - 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                    1'($urandom_range(0, 1)), 24'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_udp_line_unpack.md
Name: video_udp_line_unpack

Overview:
- Sits directly downstream of the Ethernet UDP receive parser in the video-over-Ethernet path.
- Consumes the parser's 24-bit payload words, packet-done strobe and byte count.
- Each UDP packet carries exactly one video line: a 3-byte line header followed by RGB888 pixels.
- Validates the header, converts pixels to RGB565 with x/y coordinates, and drives a write-FIFO port toward the frame buffer, with frame/line strobes and error reporting.

Parameters:
- H_PIXELS, 640: pixels per line; one line per packet.
- V_LINES, 480: lines per frame.
- HDR_MAGIC, 8'hA5: required value of header byte 0.

Ports:
- clk  in  1  system clock, the same clock as the receive parser.
- rst  in  1  reset, asynchronous, active-high.
- eth_rec_en  in  1  one-cycle strobe: rx_data_24 holds a valid 24-bit word.
- rx_data_24  in  24  payload word; [23:16] is the first byte on the wire.
- rec_pkt_done  in  1  one-cycle end-of-payload strobe.
- rec_byte_num  in  16  payload byte count; valid on the rec_pkt_done cycle.
- fifo_full  in  1  downstream write FIFO full.
- pix_wr_en  out  1  FIFO write strobe.
- pix_wr_data  out  16  RGB565 pixel.
- pix_x  out  11  column of pix_wr_data.
- pix_y  out  11  line of pix_wr_data.
- frame_start  out  1  pulse: header with line 0 accepted.
- line_done  out  1  pulse: complete line written.
- frame_done  out  1  pulse: line V_LINES-1 completed.
- err_len  out  1  pulse: packet length or pixel count wrong.
- err_seq  out  1  pulse: line number out of sequence or out of range.
- ovf  out  1  sticky: a pixel was dropped because fifo_full was high; cleared only by rst.

Behaviour:
- Reset value: every output is 0, the FSM is in S_HDR, and all counters are 0. Asserting rst mid-packet aborts the packet with no further outputs. After release, the block waits in S_HDR; the first eth_rec_en is treated as a header.
- All outputs are registered: 1 cycle of latency from the eth_rec_en or rec_pkt_done input cycle.
- Pulse outputs (frame_start, line_done, frame_done, err_len, err_seq) are high for exactly one cycle.
- Header word, the first eth_rec_en of a packet: hdr[23:16] must equal HDR_MAGIC; hdr[15:0] is the line number L.
- S_HDR, on eth_rec_en:
  - Magic mismatch: go to S_DROP; no error pulse.
  - L >= V_LINES: pulse err_seq, go to S_DROP.
  - L == 0: pulse frame_start; cur_y=0, x=0, go to S_PIX.
  - Otherwise, if L != exp_y: pulse err_seq, but still accept. cur_y=L, x=0, go to S_PIX.
- S_PIX, on eth_rec_en with x < H_PIXELS:
  - pix_wr_data = {d[23:19], d[15:10], d[7:3]}; pix_x = x; pix_y = cur_y.
  - pix_wr_en = !fifo_full. If fifo_full, the pixel is dropped and ovf is set. x increments either way.
- S_PIX, on eth_rec_en with x == H_PIXELS: no write; pulse err_len; go to S_DROP.
- On rec_pkt_done in S_PIX:
  - Good line: x == H_PIXELS and rec_byte_num == 3+3*H_PIXELS. Pulse line_done and set exp_y = cur_y+1. If cur_y == V_LINES-1, also pulse frame_done and set exp_y = 0.
  - Otherwise: pulse err_len, leave exp_y unchanged.
  - Return to S_HDR in both cases.
- rec_pkt_done in S_HDR (header-only or empty packet): pulse err_len, stay in S_HDR.
- rec_pkt_done in S_DROP: return to S_HDR, no pulse.
- eth_rec_en and rec_pkt_done in the same cycle: process the word first, then evaluate packet end including that word.
  - Example in S_PIX: the last pixel lands and line_done fires in the same output cycle.
  - In S_HDR: header is evaluated, then the header-only packet raises err_len; frame_start and err_seq may fire with it. Next state is S_HDR.
- Trailing 1-2 bytes never produce eth_rec_en; they are caught by the rec_byte_num check.
- Width rules: x and cur_y are 11 bits, exp_y is 16 bits, and L compares at 16 bits.

Test Plan:
- Good line: header {A5,0000}, 640 words 0xFF8040, pkt_done with byte_num 1923 -> frame_start once; 640 writes of pix_wr_data=0xFC08 with pix_x 0..639, pix_y=0; line_done once; no errors.
- Full frame: lines 0..479 in order -> 480 line_done, one frame_done coincident with line 479, 307200 writes, no err_seq.
- Sequence errors: line 5 after line 2 -> err_seq, 640 writes with pix_y=5. Then L=480 -> err_seq, zero writes, next packet accepted.
- Length errors: 639 pixels -> err_len, no line_done, exp_y unchanged. 641 pixels -> 640 writes, then err_len, 641st dropped. byte_num=1924 with 640 words -> err_len.
- Bad magic {5A,0003} with pixels -> no writes, no pulses; next valid packet processed normally.
- Backpressure, mid-packet rst, simultaneity:
  - fifo_full high for 10 words -> 630 writes, x continues, ovf=1 until rst.
  - rst at pixel 300 -> outputs 0; after release, a full packet passes cleanly.
  - Last word coincident with pkt_done -> write and line_done in the same cycle.
